// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: sequential double-dabble binary to packed BCD converter, one bit per clock
module binary_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction
  localparam logic [63:0] POW10 = pow10(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state_q;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d, adj, bcd_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_cap_q, ovf_q, busy_q, done_q;
  logic [4*DIGITS+WIDTH-1:0] sh;
  // add-3 correction on every digit, then shift {scratch, binary} left; the top digit's carry falls off
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (scr_q[4*i+:4] >= 4'd5) ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    sh = {adj, bin_q} << 1;
    scr_d = sh[4*DIGITS+WIDTH-1:WIDTH];
    bin_d = sh[WIDTH-1:0];
  end
  // control FSM with registered result, busy and done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scr_q;
            ovf_q   <= ovf_cap_q;
          end else begin
            scr_q <= scr_d;
            bin_q <= bin_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
            bin_q     <= bin;
            scr_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            ovf_cap_q <= 64'(bin) >= POW10;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign bcd      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed and swept checks of binary_to_bcd_seq against a decimal-arithmetic model
module tb_binary_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic [15:0] bcd;
  logic        busy, done, overflow;
  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  binary_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .bcd(bcd), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = v % 10000;
    to_bcd = '0;
    for (int i = 0; i < 4; i++) begin
      to_bcd[4*i+:4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int          cyc = 0;
  int          acc_edge = -1;
  logic [13:0] acc_bin = '0;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc_edge = -1;
      m_bcd = '0;
      m_ovf = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = (acc_edge >= 0) && (cyc == acc_edge + 15);
      if (m_done) begin
        m_bcd = to_bcd(int'(acc_bin));
        m_ovf = int'(acc_bin) >= 10000;
      end
      if (start && (acc_edge < 0 || cyc >= acc_edge + 16)) begin
        acc_edge = cyc;
        acc_bin = bin;
      end
      m_busy = (acc_edge >= 0) && (cyc < acc_edge + 15);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic dig_ok;
      dig_ok = 1'b1;
      for (int i = 0; i < 4; i++) if (bcd[4*i+:4] > 4'd9) dig_ok = 1'b0;
      check("bcd", 32'(bcd), 32'(m_bcd));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("digits_0_9", 32'(dig_ok), 32'd1);
      check("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic conv(input logic [13:0] v, input logic [15:0] eb, input logic eo, input bit lit);
    int k;
    start = 1'b1;
    bin = v;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'd16);
    if (lit) begin
      check("lit_bcd", 32'(bcd), 32'(eb));
      check("lit_ovf", 32'(overflow), 32'(eo));
    end
  endtask

  task automatic wait_done(input int k0, input int exp_k);
    int k;
    k = k0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    check("b2b_latency", 32'(k), 32'(exp_k));
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_bcd", 32'(bcd), 32'h0);
    conv(14'd0, 16'h0000, 1'b0, 1'b1);
    conv(14'd9, 16'h0009, 1'b0, 1'b1);
    conv(14'd1234, 16'h1234, 1'b0, 1'b1);
    conv(14'd9999, 16'h9999, 1'b0, 1'b1);
    conv(14'd16383, 16'h6383, 1'b1, 1'b1);
    conv(14'd10000, 16'h0000, 1'b1, 1'b1);
    conv(14'd10, 16'h0010, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin = 14'd42;
    repeat (5) @(negedge clk);
    bin = 14'd77;
    wait_done(5, 16);
    check("b2b_first", 32'(bcd), 32'h0042);
    wait_done(0, 16);
    check("b2b_second", 32'(bcd), 32'h0077);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin = 14'd5555;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    conv(14'd321, 16'h0321, 1'b0, 1'b1);
    for (int v = 0; v < 16384; v += 7) conv(14'(v), 16'h0, 1'b0, 1'b0);
    conv(14'd16383, 16'h6383, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
